// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: icache/dcache refill, write-back and uncached requests to one AXI4 master
// Ports: clk/resetn (sync, active-low); inst_rd_*/inst_ret_* and data_rd_*/data_ret_* read clients;
// data_wr_* one-entry 128-bit write buffer; ar*/r* read channels; aw*/w*/b* write channels.
// Build option BRIDGE_RAW_ADDR_CHECK_EN narrows the read-after-write block to same-line addresses.
module cache_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1,
  parameter int LINE_BEATS = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inst_rd_req,
  input  logic [2:0]   inst_rd_type,
  input  logic [31:0]  inst_rd_addr,
  output logic         inst_rd_rdy,
  output logic         inst_ret_valid,
  output logic [1:0]   inst_ret_last,
  output logic [31:0]  inst_ret_data,
  input  logic         data_rd_req,
  input  logic [2:0]   data_rd_type,
  input  logic [31:0]  data_rd_addr,
  output logic         data_rd_rdy,
  output logic         data_ret_valid,
  output logic [1:0]   data_ret_last,
  output logic [31:0]  data_ret_data,
  input  logic         data_wr_req,
  input  logic [2:0]   data_wr_type,
  input  logic [31:0]  data_wr_addr,
  input  logic [3:0]   data_wr_wstrb,
  input  logic [127:0] data_wr_data,
  output logic         data_wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);
  localparam int CW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  typedef enum logic {AR_IDLE, AR_SEND} ar_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_t;
  ar_t ar_state, ar_next;
  w_t w_state, w_next;
  logic run, raw, inst_out, data_out, inst_hs, data_hs, wr_hs, w_beat, unused_ok;
  logic [31:0] ar_addr, w_addr;
  logic [2:0] ar_type, w_type;
  logic [3:0] ar_id, w_strb;
  logic [127:0] w_buf;
  logic [CW-1:0] cnt;
  // run lags resetn by one edge so every ready/valid stays low until the edge after release
  always_ff @(posedge clk) run <= resetn;
  always_ff @(posedge clk)
    if (!resetn) begin
      ar_state <= AR_IDLE;
      w_state <= W_IDLE;
    end else begin
      ar_state <= ar_next;
      w_state <= w_next;
    end
  always_comb begin
    ar_next = ar_state == AR_IDLE ? ((inst_hs || data_hs) ? AR_SEND : AR_IDLE)
                                  : (arready ? AR_IDLE : AR_SEND);
    w_next = w_state;
    case (w_state)
      W_IDLE: w_next = wr_hs ? W_AW : W_IDLE;
      W_AW:   w_next = awready ? W_DATA : W_AW;
      W_DATA: w_next = (wready && wlast) ? W_RESP : W_DATA;
      W_RESP: w_next = bvalid ? W_IDLE : W_RESP;
      default: w_next = W_IDLE;
    endcase
  end
  always_comb begin
    data_wr_rdy = run && w_state == W_IDLE;
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    raw = (w_state != W_IDLE && data_rd_addr[31:4] == w_addr[31:4]) ||
          (data_wr_req && data_wr_rdy && data_rd_addr[31:4] == data_wr_addr[31:4]);
`else
    raw = w_state != W_IDLE || (data_wr_req && data_wr_rdy);
`endif
    data_rd_rdy = run && ar_state == AR_IDLE && !data_out && !raw;
    inst_rd_rdy = run && ar_state == AR_IDLE && !inst_out && !(data_rd_req && data_rd_rdy);
    arvalid = ar_state == AR_SEND;
    awvalid = w_state == W_AW;
    wvalid = w_state == W_DATA;
    bready = w_state == W_RESP;
    wlast = w_type[2] ? cnt == CW'(LINE_BEATS - 1) : 1'b1;
    wstrb = w_type[2] ? 4'hf : w_strb;
    wdata = w_buf[{cnt, 5'd0} +: 32];
  end
  assign inst_hs = inst_rd_req && inst_rd_rdy;
  assign data_hs = data_rd_req && data_rd_rdy;
  assign wr_hs = data_wr_req && data_wr_rdy;
  assign w_beat = wvalid && wready;
  assign arid = ar_id;
  assign araddr = ar_addr;
  assign arlen = ar_type[2] ? 8'(LINE_BEATS - 1) : 8'd0;
  assign arsize = ar_type[2] ? 3'd2 : {1'b0, ar_type[1:0]};
  assign arburst = 2'b01;
  assign awid = DATA_ID;
  assign awaddr = w_addr;
  assign awlen = w_type[2] ? 8'(LINE_BEATS - 1) : 8'd0;
  assign awsize = w_type[2] ? 3'd2 : {1'b0, w_type[1:0]};
  assign awburst = 2'b01;
  assign wid = DATA_ID;
  assign rready = run;
  assign inst_ret_valid = run && rvalid && rid == INST_ID;
  assign inst_ret_last = {1'b0, rlast};
  assign inst_ret_data = rdata;
  assign data_ret_valid = run && rvalid && rid == DATA_ID;
  assign data_ret_last = {1'b0, rlast};
  assign data_ret_data = rdata;
  assign unused_ok = ^{rresp, bresp, bid};
  always_ff @(posedge clk)
    if (!resetn) begin
      inst_out <= 1'b0;
      data_out <= 1'b0;
      cnt <= '0;
    end else begin
      inst_out <= inst_hs || (inst_out && !(inst_ret_valid && rlast));
      data_out <= data_hs || (data_out && !(data_ret_valid && rlast));
      cnt <= wr_hs ? '0 : w_beat ? cnt + 1'b1 : cnt;
    end
  always_ff @(posedge clk) begin
    if (inst_hs || data_hs) begin
      ar_addr <= data_hs ? data_rd_addr : inst_rd_addr;
      ar_type <= data_hs ? data_rd_type : inst_rd_type;
      ar_id <= data_hs ? DATA_ID : INST_ID;
    end
    if (wr_hs) begin
      w_addr <= data_wr_addr;
      w_type <= data_wr_type;
      w_strb <= data_wr_wstrb;
      w_buf <= data_wr_data;
    end
  end
endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Downstream of the instruction and data caches: converts their line-refill, write-back and uncached requests (rd_req/rd_type/rd_addr/ret_*, wr_req/wr_type/wr_addr/wr_wstrb/wr_data) into AXI4 master transactions.
- Arbitrates two read clients onto one AR channel and routes R beats back by ID.
- Serialises data-cache writes through a one-entry 128-bit write buffer.
- Blocks data reads that could overtake an in-flight write (read-after-write hazard).

Parameters:
- INST_ID, 4'd0, ARID/RID used for instruction-cache reads.
- DATA_ID, 4'd1, ARID/RID used for data-cache reads; also AWID/WID/BID for writes.
- LINE_BEATS, 4, 32-bit beats per cache line (burst arlen = LINE_BEATS-1).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_rd_req/inst_rd_type/inst_rd_addr  in  1/3/32  icache read request
- inst_rd_rdy  out  1  icache read accepted this cycle
- inst_ret_valid/inst_ret_last/inst_ret_data  out  1/2/32  icache return beat
- data_rd_req/data_rd_type/data_rd_addr  in  1/3/32  dcache read request
- data_rd_rdy  out  1  dcache read accepted this cycle
- data_ret_valid/data_ret_last/data_ret_data  out  1/2/32  dcache return beat
- data_wr_req/data_wr_type/data_wr_addr/data_wr_wstrb/data_wr_data  in  1/3/32/4/128  dcache write request
- data_wr_rdy  out  1  write buffer free
- arid/araddr/arlen/arsize/arburst  out  4/32/8/3/2  AR payload
- arvalid  out  1 ; arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  R channel ; rready  out  1
- awid/awaddr/awlen/awsize/awburst  out  4/32/8/3/2  AW payload
- awvalid  out  1 ; awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  W channel ; wready  in  1
- bid/bresp/bvalid  in  4/2/1 ; bready  out  1

Behaviour:
- Reset is synchronous on resetn low, clock clk. All FSMs go to idle, outstanding flags clear, and arvalid/awvalid/wvalid/bready/ret_valid/wr_rdy/rd_rdy are 0 until the edge after reset deasserts. In-flight transactions are abandoned, never completed.
- Type encoding:
  - 3'b100 = line burst: len = LINE_BEATS-1, size = 2, burst = INCR.
  - 3'b000/001/010 = single byte/half/word: len = 0, size = type[1:0], burst = INCR.
- AR FSM: AR_IDLE -> AR_SEND -> AR_IDLE.
  - In AR_IDLE, data_rd_rdy = no data read outstanding & no RAW block.
  - In AR_IDLE, inst_rd_rdy = no inst read outstanding & ~(data_rd_req & data_rd_rdy). Data has fixed priority.
  - On a handshake (req & rdy): latch addr/type/ID, set that client's outstanding flag, go to AR_SEND. arvalid asserts the next cycle, with payload stable until arready; return to AR_IDLE on arready.
  - At most one outstanding read per client; both clients may be outstanding simultaneously.
- R path: rready = 1 whenever out of reset.
  - Per client: ret_valid = rvalid & rid==ID; ret_data = rdata; ret_last = {1'b0, rlast}. Zero latency, combinational.
  - Outstanding flag clears on rvalid & rlast & rid match. rresp is ignored.
- W FSM: W_IDLE -> W_AW -> W_DATA -> W_RESP -> W_IDLE.
  - data_wr_rdy = (state == W_IDLE). On data_wr_req & data_wr_rdy, latch addr/type/wstrb/128-bit data into the buffer.
  - W_AW: awvalid held until awready.
  - W_DATA: beat counter cnt runs 0..LINE_BEATS-1. wdata = buf[cnt*32 +: 32]. Burst beats use wstrb = 4'hf; a single beat uses wstrb = buffered wstrb, wdata = buf[31:0]. wlast on the final beat (single: first beat). cnt advances on wvalid & wready.
  - W_RESP: bready = 1; leave on bvalid. bresp is ignored.
  - AW and W are strictly sequential: no W beat before the AW handshake.
- RAW block (default, without macro): data_rd_rdy = 0 while the W FSM is not idle, and also in any cycle where data_wr_req & data_wr_rdy.
- Instruction reads are never blocked by writes.

Optional Feature:
- Macro BRIDGE_RAW_ADDR_CHECK_EN.
- When defined: the RAW block applies only when data_rd_addr[31:4] equals the buffered write addr[31:4] (or the incoming data_wr_addr[31:4] on a same-cycle accept). Non-matching data reads proceed while the write drains.
- When undefined: the blanket block described above applies.

Test Plan:
- Icache burst, inst_rd_addr=0x1C000040, type 3'b100, arready=1 -> arid=0, araddr=0x1C000040, arlen=3, arsize=2; 4 R beats with rid=0 appear on inst_ret_*, with ret_last=2'b01 on the 4th only.
- Simultaneous inst and data read requests -> data accepted first (data_rd_rdy=1, inst_rd_rdy=0); inst accepted in the next AR_IDLE cycle; interleaved R beats routed by rid.
- Dcache write-back addr=0x00001230, data=128'h4444..._3333..._2222..._1111..., awready after 3 cycles -> awlen=3; wdata beats 0x1111..., 0x2222..., 0x3333..., 0x4444...; wlast on beat 4; data_wr_rdy returns to 1 the cycle after bvalid.
- Uncached store type 3'b000, addr 0xBFAF8001, wstrb 4'b0010 -> awsize=0, awlen=0, single beat with wstrb=0010 and wlast=1.
- RAW: write to line 0x100 in flight, then a data read of 0x104 -> data_rd_rdy=0 until bvalid. With BRIDGE_RAW_ADDR_CHECK_EN, a read of 0x200 is accepted immediately.
- resetn low during W_DATA beat 2 -> wvalid=0 next cycle, all rdy=0 during reset, W_IDLE and data_wr_rdy=1 after reset is released.
